// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, four-state debounce FSM,
// registered level plus single-cycle press/release/long-press pulses.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic long_held
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {UP, UP_CHK, DOWN, DOWN_CHK} state_t;

   state_t        state;
   logic          s1, bs;
   logic [DW-1:0] dcnt;
   logic [HW-1:0] hcnt;
   logic          in_down, long_edge;

   assign in_down   = (state == DOWN) || (state == DOWN_CHK);
   assign long_edge = in_down && (hcnt == H_PRE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1            <= 1'b0;
         bs            <= 1'b0;
         state         <= UP;
         dcnt          <= '0;
         hcnt          <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         long_held     <= 1'b0;
      end else begin
         s1            <= button;
         bs            <= s1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;

         // Hold time keeps running through release glitches; saturation
         // guarantees the long-press edge is seen once per press.
         if (in_down && hcnt != H_MAX)
            hcnt <= hcnt + 1'b1;
         if (long_edge) begin
            long_pulse <= 1'b1;
            long_held  <= 1'b1;
         end

         // Release acceptance is written last so it overrides a coincident
         // long-press edge.
         case (state)
            UP: begin
               if (bs) begin
                  state <= UP_CHK;
                  dcnt  <= DW'(1);
               end
            end
            UP_CHK: begin
               if (!bs) begin
                  state <= UP;
               end else if (dcnt == D_LAST) begin
                  state       <= DOWN;
                  level       <= 1'b1;
                  press_pulse <= 1'b1;
                  hcnt        <= '0;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            DOWN: begin
               if (!bs) begin
                  state <= DOWN_CHK;
                  dcnt  <= DW'(1);
               end
            end
            DOWN_CHK: begin
               if (bs) begin
                  state <= DOWN;
               end else if (dcnt == D_LAST) begin
                  state         <= UP;
                  level         <= 1'b0;
                  release_pulse <= 1'b1;
                  long_pulse    <= 1'b0;
                  long_held     <= 1'b0;
                  hcnt          <= '0;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: state <= UP;
         endcase
      end
   end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal timing checks
// plus randomized bouncing, all compared every cycle to a sliding-window model.
module tb_button_conditioner;
   localparam int D = 4;
   localparam int L = 10;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic button = 1'b0;
   logic level, press_pulse, release_pulse, long_pulse, long_held;

   int n_assert = 0;
   int n_fail   = 0;
   int n_press = 0, n_release = 0, n_long = 0;

   // Model state: the two-sample synchroniser delay, the last D samples it
   // delivered, and the time since the current press was accepted.
   bit p0 = 1'b0, p1 = 1'b0;
   bit win[$];
   int age = 0;
   bit m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_long = 1'b0, m_held = 1'b0;

   button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
      .clk(clk), .rst(rst), .button(button), .level(level),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .long_held(long_held)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Behavioural model: the level flips once the last D synchronised samples
   // all disagree with it; a press lasting L edges yields one long pulse.
   initial begin : model
      bit s, all_diff;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            p0 = 1'b0; p1 = 1'b0; win.delete(); age = 0;
            m_level = 1'b0; m_press = 1'b0; m_release = 1'b0;
            m_long = 1'b0; m_held = 1'b0;
         end else begin
            s = p1; p1 = p0; p0 = button;
            m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
            win.push_back(s);
            if (win.size() > D) void'(win.pop_front());
            all_diff = (win.size() == D);
            foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
            if (m_level) age++;
            if (all_diff) begin
               m_level = s;
               if (s) begin m_press = 1'b1; age = 0; end
               else begin m_release = 1'b1; m_held = 1'b0; end
            end else if (m_level && age == L) begin
               m_long = 1'b1; m_held = 1'b1;
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("level", level, m_level);
         chk("press_pulse", press_pulse, m_press);
         chk("release_pulse", release_pulse, m_release);
         chk("long_pulse", long_pulse, m_long);
         chk("long_held", long_held, m_held);
         n_press   += int'(press_pulse);
         n_release += int'(release_pulse);
         n_long    += int'(long_pulse);
      end
   end

   initial begin : stim
      int base_p, base_r, base_l, hold;
      rst = 1'b1; button = 1'b0;
      step(2);
      chk("reset_level", level, 0);
      chk("reset_press", press_pulse, 0);
      chk("reset_release", release_pulse, 0);
      chk("reset_long", long_pulse, 0);
      chk("reset_held", long_held, 0);
      rst = 1'b0;
      step(3);

      // Clean press, hold 30 cycles, release
      base_l = n_long;
      button = 1'b1;
      step(5);  chk("s1_level_e4", level, 0);
      step(1);  chk("s1_level_e5", level, 1);
                chk("s1_press_e5", press_pulse, 1);
                chk("s1_model_press_e5", m_press, 1);
      step(1);  chk("s1_press_e6", press_pulse, 0);
      step(8);  chk("s1_long_e14", long_pulse, 0);
      step(1);  chk("s1_long_e15", long_pulse, 1);
                chk("s1_held_e15", long_held, 1);
      step(1);  chk("s1_long_e16", long_pulse, 0);
                chk("s1_held_e16", long_held, 1);
      step(13);
      button = 1'b0;
      step(5);  chk("s1_release_early", release_pulse, 0);
      step(1);  chk("s1_release", release_pulse, 1);
                chk("s1_level_low", level, 0);
                chk("s1_held_clear", long_held, 0);
      chk("s1_one_long", n_long - base_l, 1);
      step(10);

      // Bounce then stable high
      base_p = n_press;
      for (int r = 0; r < 3; r++) begin
         button = 1'b1; step(3);
         button = 1'b0; step(1);
      end
      button = 1'b1;
      step(5);  chk("s2_no_press_bounce", n_press - base_p, 0);
      step(1);  chk("s2_press", press_pulse, 1);
      step(1);  chk("s2_single_press", n_press - base_p, 1);
      button = 1'b0;
      step(20);

      // Release acceptance coincides with the long-press edge
      base_l = n_long;
      button = 1'b1;
      step(6);  chk("s3_level_e", level, 1);
      step(4);  button = 1'b0;
      step(5);  chk("s3_level_e9", level, 1);
      step(1);  chk("s3_release_e10", release_pulse, 1);
                chk("s3_level_e10", level, 0);
                chk("s3_held_e10", long_held, 0);
      step(5);  chk("s3_no_long", n_long - base_l, 0);
      step(15);

      // Two-cycle glitch while down
      base_r = n_release;
      button = 1'b1;
      step(6);  chk("s4_level_e", level, 1);
      step(2);  button = 1'b0;
      step(2);  button = 1'b1;
      step(5);  chk("s4_long_e9", long_pulse, 0);
      step(1);  chk("s4_long_e10", long_pulse, 1);
                chk("s4_level_e10", level, 1);
      chk("s4_no_release", n_release - base_r, 0);
      button = 1'b0;
      step(20);

      // Long press held 40 cycles then released
      base_l = n_long;
      button = 1'b1;
      step(40);
      button = 1'b0;
      step(5);  chk("s5_held_before", long_held, 1);
      step(1);  chk("s5_release", release_pulse, 1);
                chk("s5_held_clear", long_held, 0);
      chk("s5_one_long", n_long - base_l, 1);
      step(10);

      // Reset mid-press with the button still down
      button = 1'b1;
      step(8);  chk("s6_level_before", level, 1);
      rst = 1'b1;
      #1;       chk("s6_async_level", level, 0);
                chk("s6_async_held", long_held, 0);
      step(3);
      rst = 1'b0;
      step(5);  chk("s6_press_e4", press_pulse, 0);
      step(1);  chk("s6_press_e5", press_pulse, 1);
                chk("s6_level_e5", level, 1);
      button = 1'b0;
      step(20);

      // Random bouncing segments with occasional resets
      for (int seg = 0; seg < 250; seg++) begin
         button = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            step($urandom_range(1, 3));
            rst = 1'b0;
         end
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
         step(hold);
      end
      button = 1'b0;
      step(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
